cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Initiator/reader side of the CP0 register block.
- Observes the instruction committing in writeback and picks the highest-priority exception or interrupt.
- Drives the CP0 update strobes (wb_ex/eret_flush and payload) and flushes the pipeline.
- Redirects fetch through a valid/ready handshake; also serves MFC0 reads with 1-cycle registered latency.

Parameters:
- EXC_VEC_BEV, 32'hBFC0_0380, exception entry when c0_status_bev=1
- EXC_VEC_NRM, 32'h8000_0180, exception entry when c0_status_bev=0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  instruction committing this cycle
- wb_pc_i  in  32  committing PC
- wb_bd_i  in  1  committing instr is in a delay slot
- wb_exc_i  in  7  flags {ades,adel_d,bp,sys,ov,ri,adel_f}
- wb_badvaddr_i  in  32  faulting data address
- wb_fetch_badvaddr_i  in  32  faulting fetch address (normally = wb_pc_i)
- wb_eret_i  in  1  committing instr is ERET
- c0_status_bev/exl/ie  in  1 each  from CP0
- c0_status_im  in  8  from CP0
- c0_cause_bd/ti  in  1 each;  c0_cause_ip  in  8;  c0_cause_excode  in  5
- c0_epc, c0_badvaddr, c0_count, c0_compare  in  32 each
- wb_ex  out  1  pulse to CP0
- eret_flush  out  1  pulse to CP0
- wb_excode  out  5;  wb_bd  out  1;  wb_pc  out  32;  wb_badvaddr  out  32  CP0 payload, valid with wb_ex
- pipe_flush  out  1  one-cycle flush of all stages
- redirect_valid  out  1;  redirect_pc  out  32;  redirect_ready  in  1  fetch redirect handshake
- rd_en  in  1;  raddr  in  8  {rd[4:0],sel[2:0]}
- rdata  out  32;  rdata_valid  out  1

Behaviour:
- Reset: all outputs 0, FSM=IDLE. Reset mid-handshake aborts the redirect.
- Interrupt pending: int_req = c0_status_ie & ~c0_status_exl & |(c0_cause_ip & c0_status_im).
- Interrupts attach only to a cycle with wb_valid=1.
- Priority, high to low (excode in parentheses): INT(0), adel_f(4), ri(10), ov(12), sys(8), bp(9), adel_d(4), ades(5).
- wb_badvaddr: wb_fetch_badvaddr_i for adel_f, else wb_badvaddr_i.
- Exception beats ERET in the same cycle; in that case eret_flush stays 0.
- FSM states: IDLE, FLUSH, REDIR.
- IDLE, accept cycle N (wb_valid & (any exc | int_req | wb_eret_i)): latch payload, go to FLUSH.
- FLUSH, cycle N+1: exactly one of wb_ex / eret_flush =1; pipe_flush=1; go to REDIR.
- REDIR: redirect_valid=1, redirect_pc held constant.
  - Exception target: bev ? EXC_VEC_BEV : EXC_VEC_NRM, using bev sampled at accept.
  - ERET target: c0_epc sampled in FLUSH, i.e. after any prior CP0 write settles.
- REDIR exit: on redirect_ready=1, return to IDLE the next cycle. No timeout; redirect_valid holds indefinitely.
- wb_valid is ignored in FLUSH/REDIR, since those instructions are flushed.
- Pulses last exactly 1 cycle; payload outputs are 0 whenever wb_ex=0.
- MFC0 reads: registered. rd_en at cycle N gives rdata/rdata_valid at N+1.
  - rdata_valid=0 otherwise; rdata keeps its last value.
  - Read values by raddr:
    - 8'h40 BadVAddr
    - 8'h48 Count
    - 8'h58 Compare
    - 8'h60 Status = {9'b0,bev,6'b0,im,6'b0,exl,ie}
    - 8'h68 Cause = {bd,ti,14'b0,ip,1'b0,excode,2'b0}
    - 8'h70 EPC
    - any other address reads 32'h0
  - Reads are served in every FSM state.

Decomposition:
- Shared package/define file holds:
  - CR_* address constants (BADVADDR 8'h40, COUNT 8'h48, COMPARE 8'h58, STATUS 8'h60, CAUSE 8'h68, EPC 8'h70)
  - EX_* excodes (INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12)
  - wb_exc_i bit indices
  - FSM state encodings
- One sub-module: cp0_exc_prio, a combinational priority encoder from flags + int_req to {hit, excode, use_fetch_addr}.

Test Plan:
- ri only, wb_pc_i=0xBFC00010, bev=1, ready=1 at N+2:
  - N+1: wb_ex=1, excode=10, pipe_flush=1
  - N+2: redirect_pc=0xBFC00380
  - N+3: FSM back to IDLE
- ov + sys + adel_d together, wb_bd_i=1, bev=0:
  - excode=12, wb_bd=1, redirect_pc=0x80000180
- ERET with c0_epc=0xBFC00100 and no exception:
  - eret_flush=1, wb_ex=0, redirect_pc=0xBFC00100
- ERET together with sys:
  - wb_ex=1, excode=8, eret_flush=0
- Interrupt gating: ip=8'h80, im=8'h80, ie=1:
  - exl=0: wb_ex, excode=0
  - exl=1: no action
  - wb_valid=0: no action
- MFC0 raddr=8'h68 with bd=1, ti=1, ip=8'h81, excode=4:
  - next cycle rdata=0xC000_8110, rdata_valid=1
- MFC0 raddr=8'h99:
  - rdata=0

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception controller: MFC0 register addresses,
// exception codes, wb_exc_i flag positions and the controller state type.
package cp0_exc_ctrl_pkg;

    localparam logic [7:0] CR_BADVADDR = 8'h40;
    localparam logic [7:0] CR_COUNT    = 8'h48;
    localparam logic [7:0] CR_COMPARE  = 8'h58;
    localparam logic [7:0] CR_STATUS   = 8'h60;
    localparam logic [7:0] CR_CAUSE    = 8'h68;
    localparam logic [7:0] CR_EPC      = 8'h70;

    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;

    // wb_exc_i = {ades, adel_d, bp, sys, ov, ri, adel_f}
    localparam int unsigned EXC_W      = 7;
    localparam int unsigned EXC_ADEL_F = 0;
    localparam int unsigned EXC_RI     = 1;
    localparam int unsigned EXC_OV     = 2;
    localparam int unsigned EXC_SYS    = 3;
    localparam int unsigned EXC_BP     = 4;
    localparam int unsigned EXC_ADEL_D = 5;
    localparam int unsigned EXC_ADES   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } exc_state_e;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational priority encoder: picks the winning interrupt/exception of the
// committing instruction and reports whether the fetch address is the fault address.
module cp0_exc_prio
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [EXC_W-1:0] exc_i,
    input  logic             int_req_i,
    output logic             hit_o,
    output logic [4:0]       excode_o,
    output logic             use_fetch_addr_o
);

    always_comb begin
        hit_o            = 1'b1;
        excode_o         = EX_INT;
        use_fetch_addr_o = 1'b0;
        if (int_req_i) begin
            excode_o = EX_INT;
        end else if (exc_i[EXC_ADEL_F]) begin
            excode_o         = EX_ADEL;
            use_fetch_addr_o = 1'b1;
        end else if (exc_i[EXC_RI]) begin
            excode_o = EX_RI;
        end else if (exc_i[EXC_OV]) begin
            excode_o = EX_OV;
        end else if (exc_i[EXC_SYS]) begin
            excode_o = EX_SYS;
        end else if (exc_i[EXC_BP]) begin
            excode_o = EX_BP;
        end else if (exc_i[EXC_ADEL_D]) begin
            excode_o = EX_ADEL;
        end else if (exc_i[EXC_ADES]) begin
            excode_o = EX_ADES;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET controller: raises CP0 update strobes, flushes the pipeline,
// redirects fetch via valid/ready, and serves registered MFC0 reads.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC_BEV = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC_NRM = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_bd_i,
    input  logic [6:0]  wb_exc_i,
    input  logic [31:0] wb_badvaddr_i,
    input  logic [31:0] wb_fetch_badvaddr_i,
    input  logic        wb_eret_i,
    input  logic        c0_status_bev,
    input  logic        c0_status_exl,
    input  logic        c0_status_ie,
    input  logic [7:0]  c0_status_im,
    input  logic        c0_cause_bd,
    input  logic        c0_cause_ti,
    input  logic [7:0]  c0_cause_ip,
    input  logic [4:0]  c0_cause_excode,
    input  logic [31:0] c0_epc,
    input  logic [31:0] c0_badvaddr,
    input  logic [31:0] c0_count,
    input  logic [31:0] c0_compare,
    output logic        wb_ex,
    output logic        eret_flush,
    output logic [4:0]  wb_excode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    input  logic        rd_en,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata,
    output logic        rdata_valid
);

    exc_state_e  state_q, state_d;
    logic        wb_ex_q, wb_ex_d;
    logic        eret_flush_q, eret_flush_d;
    logic        pipe_flush_q, pipe_flush_d;
    logic [4:0]  wb_excode_q, wb_excode_d;
    logic        wb_bd_q, wb_bd_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_badvaddr_q, wb_badvaddr_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        bev_q, bev_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;

    logic        int_req;
    logic        accept;
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic        use_fetch_addr;
    logic [31:0] rd_value;

    cp0_exc_prio u_prio (
        .exc_i            (wb_exc_i),
        .int_req_i        (int_req),
        .hit_o            (exc_hit),
        .excode_o         (exc_code),
        .use_fetch_addr_o (use_fetch_addr)
    );

    assign int_req = c0_status_ie & ~c0_status_exl & (|(c0_cause_ip & c0_status_im));
    assign accept  = wb_valid & ((|wb_exc_i) | int_req | wb_eret_i);

    always_comb begin
        state_d          = state_q;
        wb_ex_d          = 1'b0;
        eret_flush_d     = 1'b0;
        pipe_flush_d     = 1'b0;
        wb_excode_d      = '0;
        wb_bd_d          = 1'b0;
        wb_pc_d          = '0;
        wb_badvaddr_d    = '0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        bev_d            = bev_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_FLUSH;
                    pipe_flush_d = 1'b1;
                    bev_d        = c0_status_bev;
                    // An exception always wins over ERET; ERET only fires when nothing hit.
                    if (exc_hit) begin
                        wb_ex_d       = 1'b1;
                        wb_excode_d   = exc_code;
                        wb_bd_d       = wb_bd_i;
                        wb_pc_d       = wb_pc_i;
                        wb_badvaddr_d = use_fetch_addr ? wb_fetch_badvaddr_i : wb_badvaddr_i;
                    end else begin
                        eret_flush_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                state_d          = ST_REDIR;
                redirect_valid_d = 1'b1;
                // EPC is sampled here so a CP0 write retiring alongside the flush is seen.
                redirect_pc_d    = wb_ex_q ? (bev_q ? EXC_VEC_BEV : EXC_VEC_NRM) : c0_epc;
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d          = ST_IDLE;
                    redirect_valid_d = 1'b0;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                redirect_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        unique case (raddr)
            CR_BADVADDR: rd_value = c0_badvaddr;
            CR_COUNT:    rd_value = c0_count;
            CR_COMPARE:  rd_value = c0_compare;
            CR_STATUS:   rd_value = {9'b0, c0_status_bev, 6'b0, c0_status_im, 6'b0,
                                     c0_status_exl, c0_status_ie};
            CR_CAUSE:    rd_value = {c0_cause_bd, c0_cause_ti, 14'b0, c0_cause_ip, 1'b0,
                                     c0_cause_excode, 2'b0};
            CR_EPC:      rd_value = c0_epc;
            default:     rd_value = '0;
        endcase
        rdata_valid_d = rd_en;
        rdata_d       = rd_en ? rd_value : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wb_ex_q          <= 1'b0;
            eret_flush_q     <= 1'b0;
            pipe_flush_q     <= 1'b0;
            wb_excode_q      <= '0;
            wb_bd_q          <= 1'b0;
            wb_pc_q          <= '0;
            wb_badvaddr_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            bev_q            <= 1'b0;
            rdata_q          <= '0;
            rdata_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            wb_ex_q          <= wb_ex_d;
            eret_flush_q     <= eret_flush_d;
            pipe_flush_q     <= pipe_flush_d;
            wb_excode_q      <= wb_excode_d;
            wb_bd_q          <= wb_bd_d;
            wb_pc_q          <= wb_pc_d;
            wb_badvaddr_q    <= wb_badvaddr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            bev_q            <= bev_d;
            rdata_q          <= rdata_d;
            rdata_valid_q    <= rdata_valid_d;
        end
    end

    assign wb_ex          = wb_ex_q;
    assign eret_flush     = eret_flush_q;
    assign pipe_flush     = pipe_flush_q;
    assign wb_excode      = wb_excode_q;
    assign wb_bd          = wb_bd_q;
    assign wb_pc          = wb_pc_q;
    assign wb_badvaddr    = wb_badvaddr_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign rdata          = rdata_q;
    assign rdata_valid    = rdata_valid_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed stimulus, a cycle-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_bd_i, wb_eret_i;
    logic [31:0] wb_pc_i, wb_badvaddr_i, wb_fetch_badvaddr_i;
    logic [6:0]  wb_exc_i;
    logic        c0_status_bev, c0_status_exl, c0_status_ie;
    logic [7:0]  c0_status_im, c0_cause_ip;
    logic        c0_cause_bd, c0_cause_ti;
    logic [4:0]  c0_cause_excode;
    logic [31:0] c0_epc, c0_badvaddr, c0_count, c0_compare;
    logic        wb_ex, eret_flush, wb_bd, pipe_flush, redirect_valid, redirect_ready;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, redirect_pc, rdata;
    logic        rd_en, rdata_valid;
    logic [7:0]  raddr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl #(
        .EXC_VEC_BEV (32'hBFC0_0380),
        .EXC_VEC_NRM (32'h8000_0180)
    ) dut (
        .clk (clk), .reset (reset),
        .wb_valid (wb_valid), .wb_pc_i (wb_pc_i), .wb_bd_i (wb_bd_i), .wb_exc_i (wb_exc_i),
        .wb_badvaddr_i (wb_badvaddr_i), .wb_fetch_badvaddr_i (wb_fetch_badvaddr_i),
        .wb_eret_i (wb_eret_i),
        .c0_status_bev (c0_status_bev), .c0_status_exl (c0_status_exl),
        .c0_status_ie (c0_status_ie), .c0_status_im (c0_status_im),
        .c0_cause_bd (c0_cause_bd), .c0_cause_ti (c0_cause_ti), .c0_cause_ip (c0_cause_ip),
        .c0_cause_excode (c0_cause_excode),
        .c0_epc (c0_epc), .c0_badvaddr (c0_badvaddr), .c0_count (c0_count),
        .c0_compare (c0_compare),
        .wb_ex (wb_ex), .eret_flush (eret_flush), .wb_excode (wb_excode), .wb_bd (wb_bd),
        .wb_pc (wb_pc), .wb_badvaddr (wb_badvaddr), .pipe_flush (pipe_flush),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .redirect_ready (redirect_ready),
        .rd_en (rd_en), .raddr (raddr), .rdata (rdata), .rdata_valid (rdata_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Priority listed as an ordered table: flag bit i has code codes[i]; lower i wins.
    function automatic logic [6:0] prio_model(input logic [6:0] flags, input logic irq);
        int codes [7];
        codes = '{4, 10, 12, 8, 9, 4, 5};
        if (irq) return 7'b1_0_00000;
        for (int i = 0; i < 7; i++) begin
            if (flags[i]) return {1'b1, (i == 0), 5'(codes[i])};
        end
        return '0;
    endfunction

    function automatic logic [31:0] mfc0_model(input logic [7:0] a);
        case (a)
            8'h40:   return c0_badvaddr;
            8'h48:   return c0_count;
            8'h58:   return c0_compare;
            8'h60:   return {9'b0, c0_status_bev, 6'b0, c0_status_im, 6'b0, c0_status_exl, c0_status_ie};
            8'h68:   return {c0_cause_bd, c0_cause_ti, 14'b0, c0_cause_ip, 1'b0, c0_cause_excode, 2'b0};
            8'h70:   return c0_epc;
            default: return 32'h0;
        endcase
    endfunction

    logic       m_irq;
    logic [6:0] m_pr;
    assign m_irq = c0_status_ie & ~c0_status_exl & (|(c0_cause_ip & c0_status_im));
    assign m_pr  = prio_model(wb_exc_i, m_irq);

    logic        m_live = 1'b0, m_redir = 1'b0, m_after_pulse = 1'b0, m_pend_exc = 1'b0;
    logic [31:0] m_pend_vec = '0;
    logic        e_wb_ex, e_eret, e_flush, e_bd, e_rv, e_rdv;
    logic [4:0]  e_excode;
    logic [31:0] e_pc, e_bva, e_rpc, e_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_live <= 1'b1; m_redir <= 1'b0; m_after_pulse <= 1'b0;
            e_wb_ex <= 1'b0; e_eret <= 1'b0; e_flush <= 1'b0; e_bd <= 1'b0;
            e_excode <= '0; e_pc <= '0; e_bva <= '0;
            e_rv <= 1'b0; e_rpc <= '0; e_rdv <= 1'b0; e_rdata <= '0;
        end else begin
            e_rdv <= rd_en;
            if (rd_en) e_rdata <= mfc0_model(raddr);
            e_wb_ex <= 1'b0; e_eret <= 1'b0; e_flush <= 1'b0; e_bd <= 1'b0;
            e_excode <= '0; e_pc <= '0; e_bva <= '0;
            m_after_pulse <= 1'b0;
            if (m_redir) begin
                if (redirect_ready) begin
                    m_redir <= 1'b0;
                    e_rv    <= 1'b0;
                end
            end else if (m_after_pulse) begin
                m_redir <= 1'b1;
                e_rv    <= 1'b1;
                e_rpc   <= m_pend_exc ? m_pend_vec : c0_epc;
            end else if (wb_valid && (m_pr[6] || wb_eret_i)) begin
                m_after_pulse <= 1'b1;
                e_flush       <= 1'b1;
                if (m_pr[6]) begin
                    e_wb_ex    <= 1'b1;
                    e_excode   <= m_pr[4:0];
                    e_bd       <= wb_bd_i;
                    e_pc       <= wb_pc_i;
                    e_bva      <= m_pr[5] ? wb_fetch_badvaddr_i : wb_badvaddr_i;
                    m_pend_exc <= 1'b1;
                    m_pend_vec <= c0_status_bev ? 32'hBFC0_0380 : 32'h8000_0180;
                end else begin
                    e_eret     <= 1'b1;
                    m_pend_exc <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_wb_ex",       32'(wb_ex),          32'(e_wb_ex));
            check("m_eret_flush",  32'(eret_flush),     32'(e_eret));
            check("m_pipe_flush",  32'(pipe_flush),     32'(e_flush));
            check("m_wb_excode",   32'(wb_excode),      32'(e_excode));
            check("m_wb_bd",       32'(wb_bd),          32'(e_bd));
            check("m_wb_pc",       wb_pc,               e_pc);
            check("m_wb_badvaddr", wb_badvaddr,         e_bva);
            check("m_redir_valid", 32'(redirect_valid), 32'(e_rv));
            if (e_rv) check("m_redir_pc", redirect_pc, e_rpc);
            check("m_rdata_valid", 32'(rdata_valid),    32'(e_rdv));
            check("m_rdata",       rdata,               e_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet();
        wb_valid = 1'b0; wb_exc_i = '0; wb_eret_i = 1'b0; wb_bd_i = 1'b0;
    endtask

    task automatic drain();
        quiet();
        redirect_ready = 1'b1;
        step(4);
        check("drain_redir_valid", 32'(redirect_valid), 0);
        redirect_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; quiet();
        wb_pc_i = '0; wb_badvaddr_i = '0; wb_fetch_badvaddr_i = '0;
        c0_status_bev = 1'b0; c0_status_exl = 1'b0; c0_status_ie = 1'b0; c0_status_im = '0;
        c0_cause_bd = 1'b0; c0_cause_ti = 1'b0; c0_cause_ip = '0; c0_cause_excode = '0;
        c0_epc = 32'h0; c0_badvaddr = 32'h0; c0_count = 32'h0; c0_compare = 32'h0;
        redirect_ready = 1'b0; rd_en = 1'b1; raddr = 8'h48; c0_count = 32'h55;
        wb_valid = 1'b1; wb_exc_i = 7'b0000010;
        step(3);
        check("rst_wb_ex",       32'(wb_ex), 0);
        check("rst_pipe_flush",  32'(pipe_flush), 0);
        check("rst_redir_valid", 32'(redirect_valid), 0);
        check("rst_rdata_valid", 32'(rdata_valid), 0);
        check("rst_rdata",       rdata, 0);
        reset = 1'b0; quiet(); rd_en = 1'b0;
        step(2);

        // RI, bev=1; bev changed after accept must not affect target
        wb_valid = 1'b1; wb_exc_i = 7'b0000010; wb_pc_i = 32'hBFC0_0010; c0_status_bev = 1'b1;
        step();
        check("ri_wb_ex", 32'(wb_ex), 1);
        check("ri_excode", 32'(wb_excode), 10);
        check("ri_pipe_flush", 32'(pipe_flush), 1);
        check("ri_wb_pc", wb_pc, 32'hBFC0_0010);
        quiet(); c0_status_bev = 1'b0;
        step();
        check("ri_redir_valid", 32'(redirect_valid), 1);
        check("ri_redir_pc", redirect_pc, 32'hBFC0_0380);
        check("ri_flush_pulse", 32'(pipe_flush), 0);
        redirect_ready = 1'b1;
        step();
        check("ri_idle", 32'(redirect_valid), 0);
        redirect_ready = 1'b0;
        step();

        // ov+sys+adel_d in delay slot, bev=0; wb_valid ignored while redirecting
        wb_valid = 1'b1; wb_exc_i = 7'b0101100; wb_bd_i = 1'b1; wb_pc_i = 32'h8000_2000;
        wb_badvaddr_i = 32'h1234_5678; wb_fetch_badvaddr_i = 32'hDEAD_0000;
        step();
        check("ov_excode", 32'(wb_excode), 12);
        check("ov_bd", 32'(wb_bd), 1);
        check("ov_badvaddr", wb_badvaddr, 32'h1234_5678);
        wb_exc_i = 7'b0001000;
        step();
        check("ov_redir_pc", redirect_pc, 32'h8000_0180);
        step(3);
        check("hold_redir_valid", 32'(redirect_valid), 1);
        check("hold_redir_pc", redirect_pc, 32'h8000_0180);
        check("hold_no_flush", 32'(pipe_flush), 0);
        drain();

        // ERET: EPC taken from the FLUSH cycle, not the accept cycle
        wb_valid = 1'b1; wb_eret_i = 1'b1; c0_epc = 32'h1111_1111;
        step();
        check("eret_flush", 32'(eret_flush), 1);
        check("eret_wb_ex", 32'(wb_ex), 0);
        check("eret_payload", wb_pc, 0);
        quiet(); c0_epc = 32'hBFC0_0100;
        step();
        check("eret_redir_pc", redirect_pc, 32'hBFC0_0100);
        drain();

        // ERET with SYS: exception wins
        wb_valid = 1'b1; wb_eret_i = 1'b1; wb_exc_i = 7'b0001000;
        step();
        check("eretsys_wb_ex", 32'(wb_ex), 1);
        check("eretsys_excode", 32'(wb_excode), 8);
        check("eretsys_eret", 32'(eret_flush), 0);
        drain();

        // adel_f beats ades and reports the fetch address
        wb_valid = 1'b1; wb_exc_i = 7'b1000001; wb_fetch_badvaddr_i = 32'hBFC0_0002;
        step();
        check("adelf_excode", 32'(wb_excode), 4);
        check("adelf_badvaddr", wb_badvaddr, 32'hBFC0_0002);
        drain();
        wb_valid = 1'b1; wb_exc_i = 7'b1000000;
        step();
        check("ades_excode", 32'(wb_excode), 5);
        check("ades_badvaddr", wb_badvaddr, 32'h1234_5678);
        drain();
        wb_valid = 1'b1; wb_exc_i = 7'b0010000;
        step();
        check("bp_excode", 32'(wb_excode), 9);
        drain();

        // Interrupt gating; interrupt outranks RI
        c0_cause_ip = 8'h80; c0_status_im = 8'h80; c0_status_ie = 1'b1; c0_status_exl = 1'b0;
        wb_valid = 1'b1; wb_exc_i = 7'b0000010;
        step();
        check("int_wb_ex", 32'(wb_ex), 1);
        check("int_excode", 32'(wb_excode), 0);
        drain();
        c0_status_exl = 1'b1; wb_valid = 1'b1;
        step();
        check("int_exl_none", 32'(pipe_flush), 0);
        c0_status_exl = 1'b0; wb_valid = 1'b0;
        step();
        check("int_novalid_none", 32'(pipe_flush), 0);
        c0_status_ie = 1'b0; c0_cause_ip = 8'h00;
        step();

        // MFC0 reads
        c0_cause_bd = 1'b1; c0_cause_ti = 1'b1; c0_cause_ip = 8'h81; c0_cause_excode = 5'd4;
        rd_en = 1'b1; raddr = 8'h68;
        step();
        check("rd_cause", rdata, 32'hC000_8110);
        check("rd_cause_valid", 32'(rdata_valid), 1);
        raddr = 8'h99;
        step();
        check("rd_unmapped", rdata, 32'h0);
        rd_en = 1'b0; raddr = 8'h68;
        step();
        check("rd_idle_valid", 32'(rdata_valid), 0);
        check("rd_idle_hold", rdata, 32'h0);
        c0_status_bev = 1'b1; c0_status_im = 8'hA5; c0_status_exl = 1'b1; c0_status_ie = 1'b0;
        rd_en = 1'b1; raddr = 8'h60;
        step();
        check("rd_status", rdata, 32'h0040_A502);
        rd_en = 1'b0; c0_status_exl = 1'b0; c0_status_im = 8'h00; c0_cause_ip = 8'h00;
        step();

        // Read during REDIR, then reset aborts the handshake
        wb_valid = 1'b1; wb_exc_i = 7'b0000100;
        step();
        quiet(); rd_en = 1'b1; raddr = 8'h70; c0_epc = 32'hCAFE_0004;
        step(2);
        check("redir_rd_epc", rdata, 32'hCAFE_0004);
        check("redir_active", 32'(redirect_valid), 1);
        rd_en = 1'b0; reset = 1'b1;
        step();
        check("abort_redir_valid", 32'(redirect_valid), 0);
        check("abort_rdata", rdata, 0);
        reset = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
